lcd_pclk_gen: RTL and testbench

Parametrised LCD pixel-clock generator for the RGB LCD path, replacing the fixed three-ratio divider. Derives the panel pixel clock from the 100 MHz system clock. Any integer ratio from 2 to 2^DIV_W-1 is selected at runtime, either from the panel ID or from an explicit override. Ratio changes take effect glitch-free at a period boundary. Same-domain strobes at the pixel-clock rising and falling edges let downstream timing logic run on `clk` with enables.

---
 rtl/lcd_pclk_pkg.sv | 14 +
 rtl/lcd_pclk_lut.sv | 19 +
 rtl/lcd_pclk_gen.sv | 77 +++++++
 tb/tb_lcd_pclk_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pclk_pkg.sv
// Shared constants for the LCD pixel-clock generator: panel IDs, their divisors, and the divisor floor.
package lcd_pclk_pkg;
  localparam logic [15:0] ID_4342 = 16'h0000;
  localparam logic [15:0] ID_7084 = 16'h0001;
  localparam logic [15:0] ID_7016 = 16'h0002;
  localparam logic [15:0] ID_1018 = 16'h0005;

  localparam int DIV_4342  = 10;
  localparam int DIV_7084  = 3;
  localparam int DIV_7016  = 2;
  localparam int DIV_1018  = 2;
  localparam int DIV_DEFID = 3;
  localparam int DIV_MIN   = 2;
endpackage

// File: rtl/lcd_pclk_lut.sv
// Combinational panel-ID to pixel-clock divisor table; also used by the LCD timing controller.
module lcd_pclk_lut
  import lcd_pclk_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic [15:0]      lcd_id,
  output logic [DIV_W-1:0] div
);
  always_comb begin
    case (lcd_id)
      ID_4342: div = DIV_W'(DIV_4342);
      ID_7084: div = DIV_W'(DIV_7084);
      ID_7016: div = DIV_W'(DIV_7016);
      ID_1018: div = DIV_W'(DIV_1018);
      default: div = DIV_W'(DIV_DEFID);
    endcase
  end
endmodule

// File: rtl/lcd_pclk_gen.sv
// Runtime-programmable LCD pixel-clock divider with glitch-free switching at period boundaries.
// Define LCD_PCLK_DUTY50_EN to stretch the high phase by half a clk for odd divisors (exact 50 % duty).
module lcd_pclk_gen
  import lcd_pclk_pkg::*;
#(
  parameter int DIV_W   = 5,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      lcd_id,
  input  logic             div_ovr_en,
  input  logic [DIV_W-1:0] div_ovr,
  output logic             clk_lcd,
  output logic             pclk_rise,
  output logic             pclk_fall,
  output logic [DIV_W-1:0] cur_div,
  output logic             div_busy
);
  logic [DIV_W-1:0] lut_div, tgt_raw, tgt;
  logic [DIV_W-1:0] req_div_q, cur_div_q, cnt_q;
  logic [DIV_W-1:0] cur_div_d, cnt_d, half_d;
  logic             wrap;
  logic             clk_base_q, rise_q, fall_q, busy_q;

  lcd_pclk_lut #(.DIV_W(DIV_W)) u_lut (
    .lcd_id (lcd_id),
    .div    (lut_div)
  );

  always_comb begin
    tgt_raw   = div_ovr_en ? div_ovr : lut_div;
    tgt       = (tgt_raw < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : tgt_raw;
    wrap      = (cnt_q == cur_div_q - DIV_W'(1));
    cur_div_d = wrap ? req_div_q : cur_div_q;
    cnt_d     = wrap ? '0 : cnt_q + DIV_W'(1);
    half_d    = cur_div_d >> 1;
  end

  // Outputs derive from next-state values so they line up with the counter after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_div_q  <= DIV_W'(DEF_DIV);
      cur_div_q  <= DIV_W'(DEF_DIV);
      cnt_q      <= DIV_W'(DEF_DIV - 1);
      clk_base_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      req_div_q  <= tgt;
      cur_div_q  <= cur_div_d;
      cnt_q      <= cnt_d;
      clk_base_q <= (cnt_d < half_d);
      rise_q     <= (cnt_d == '0);
      fall_q     <= (cnt_d == half_d);
      busy_q     <= (tgt != cur_div_d);
    end
  end

`ifdef LCD_PCLK_DUTY50_EN
  // Holds the high phase over the next clk low half when the divisor is odd.
  logic ext_q;
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) ext_q <= 1'b0;
    else        ext_q <= clk_base_q & cur_div_q[0];
  end
  assign clk_lcd = clk_base_q | ext_q;
`else
  assign clk_lcd = clk_base_q;
`endif

  assign pclk_rise = rise_q;
  assign pclk_fall = fall_q;
  assign cur_div   = cur_div_q;
  assign div_busy  = busy_q;
endmodule

// File: tb/tb_lcd_pclk_gen.sv
// Scoreboard bench for lcd_pclk_gen: a period-list waveform model queues expected outputs per cycle.
module tb_lcd_pclk_gen;
  localparam int DIV_W = 5;
  localparam int DEF_DIV = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      lcd_id = 16'h0001;
  logic             div_ovr_en = 1'b0;
  logic [DIV_W-1:0] div_ovr = '0;
  logic             clk_lcd, pclk_rise, pclk_fall, div_busy;
  logic [DIV_W-1:0] cur_div;

  lcd_pclk_gen #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_id(lcd_id), .div_ovr_en(div_ovr_en),
    .div_ovr(div_ovr), .clk_lcd(clk_lcd), .pclk_rise(pclk_rise),
    .pclk_fall(pclk_fall), .cur_div(cur_div), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit c; bit r; bit f; bit b; int cur; } exp_t;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: requested divisor, divisor in force, remaining positions of the current period.
  int mreq, mcur;
  int mper[$];

  longint t_r = 0, t_f = 0, hi_w = 0, lo_w = 0;
  always @(posedge clk_lcd) begin lo_w = $time - t_f; t_r = $time; end
  always @(negedge clk_lcd) begin hi_w = $time - t_r; t_f = $time; end

  function automatic int ref_div(logic [15:0] id, logic en, logic [DIV_W-1:0] ovr);
    int v;
    if (en) v = int'(ovr);
    else begin
      case (id)
        16'h0000: v = 10;
        16'h0001: v = 3;
        16'h0002: v = 2;
        16'h0005: v = 2;
        default:  v = 3;
      endcase
    end
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    mreq = DEF_DIV; mcur = DEF_DIV; mper.delete();
  endtask

  task automatic model_edge();
    exp_t e;
    int k;
    if (mper.size() == 0) begin
      mcur = mreq;
      for (int i = 0; i < mcur; i++) mper.push_back(i);
    end
    k = mper.pop_front();
    mreq = ref_div(lcd_id, div_ovr_en, div_ovr);
    e.c = (k < mcur / 2); e.r = (k == 0); e.f = (k == mcur / 2);
    e.b = (mreq != mcur); e.cur = mcur;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1; model_edge();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_clk_lcd"}, int'(clk_lcd), 0);
    chk({tag, "_rise"}, int'(pclk_rise), 0);
    chk({tag, "_fall"}, int'(pclk_fall), 0);
    chk({tag, "_cur_div"}, int'(cur_div), DEF_DIV);
    chk({tag, "_busy"}, int'(div_busy), 0);
  endtask

  task automatic wait_pos(int div, int left, string name);
    int n = 0;
    while (!(mcur == div && mper.size() == left) && n < 80) begin step(); n++; end
    if (n >= 80) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic rand_inputs();
    int sel;
    if ($urandom_range(3) == 0) begin
      div_ovr_en = ($urandom_range(2) == 0);
      div_ovr = DIV_W'($urandom);
      sel = $urandom_range(5);
      case (sel)
        0: lcd_id = 16'h0000; 1: lcd_id = 16'h0001; 2: lcd_id = 16'h0002;
        3: lcd_id = 16'h0005; default: lcd_id = 16'($urandom);
      endcase
    end
  endtask

  // Monitor: compares the DUT against the queued expectation each cycle, away from both edges.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #7;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (clk_lcd !== e.c || pclk_rise !== e.r || pclk_fall !== e.f ||
            div_busy !== e.b || int'(cur_div) != e.cur) begin
          errors++;
          $display("FAIL cycle@%0t: got clk=%b rise=%b fall=%b busy=%b cur=%0d expected clk=%b rise=%b fall=%b busy=%b cur=%0d",
                   $time, clk_lcd, pclk_rise, pclk_fall, div_busy, cur_div,
                   e.c, e.r, e.f, e.b, e.cur);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #3 chk_reset_vals("reset");
    @(posedge clk); #3 rst_n = 1'b1;

    // Default panel at div 3, then duty measurement.
    run(30);
`ifdef LCD_PCLK_DUTY50_EN
    chk("duty_high_div3", int'(hi_w), 15);
    chk("duty_low_div3", int'(lo_w), 15);
`else
    chk("duty_high_div3", int'(hi_w), 10);
    chk("duty_low_div3", int'(lo_w), 20);
`endif

    // Mid-period panel switch to the 10-cycle panel.
    wait_pos(3, 1, "align_id");
    lcd_id = 16'h0000;
    run(40);

    // Override clamp: 0 and 1 both give 2.
    div_ovr_en = 1'b1; div_ovr = '0;
    run(12);
    div_ovr = DIV_W'(1);
    run(12);

    // Request 10 then back to 3 before the wrap: busy pulse, no switch.
    div_ovr = DIV_W'(3);
    run(8);
    wait_pos(3, 2, "align_pulse");
    div_ovr = DIV_W'(10);
    step();
    div_ovr = DIV_W'(3);
    run(12);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin step(); rand_inputs(); end

    // Reset asserted in the high phase at div 10.
    div_ovr_en = 1'b1; div_ovr = DIV_W'(10);
    wait_pos(10, 8, "align_rst");
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(posedge clk); #3 rst_n = 1'b1;
    model_reset();
    run(30);
    for (int i = 0; i < 150; i++) begin step(); rand_inputs(); end

    @(posedge clk); #8;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
